// File: rtl/jam_light_sequencer.sv
// jam_light_sequencer: serves jammed roads one at a time, round-robin.
// It handshakes with jam_counter through jam_counter_en, jam_start and
// jam_rotation. Each green window is followed by a yellow phase and one
// all-red clearance cycle. Every output is taken straight from a flop.
module jam_light_sequencer #(
  parameter int N_ROADS       = 4,
  parameter int YELLOW_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_ROADS-1:0]         jam_roads,
  input  logic                       jam_start,
  input  logic                       jam_rotation,
  output logic                       jam_counter_en,
  output logic [N_ROADS-1:0]         green,
  output logic [N_ROADS-1:0]         yellow,
  output logic [N_ROADS-1:0]         red,
  output logic [$clog2(N_ROADS)-1:0] active_road,
  output logic                       jam_mode
);

  localparam int RW = $clog2(N_ROADS);
  localparam int CW = $clog2(YELLOW_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARM, GREEN, YELLOW, ALL_RED} state_t;

  state_t               state, state_n;
  logic [RW-1:0]        last_road, last_road_n, active_road_n;
  logic [CW-1:0]        ycnt, ycnt_n;
  logic [N_ROADS-1:0]   green_n, yellow_n;
  logic                 en_n;
  logic [RW-1:0]        sel;

  // Round-robin pick: first jammed road after 'last', wrapping, with 'last'
  // itself as the final candidate so a lone jammed road is served again.
  function automatic logic [RW-1:0] rr_pick(input logic [N_ROADS-1:0] req,
                                            input logic [RW-1:0]      last);
    logic [RW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N_ROADS; k++) begin
      idx = int'(last) + k;
      if (idx >= N_ROADS) idx = idx - N_ROADS;
      if (!found && req[idx]) begin
        pick  = RW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign sel = rr_pick(jam_roads, last_road);

  // Next-state and next-output logic; lamps and enable are computed here
  // and registered below, so the outputs change on the deciding edge.
  always_comb begin
    state_n       = state;
    green_n       = green;
    yellow_n      = yellow;
    en_n          = jam_counter_en;
    active_road_n = active_road;
    last_road_n   = last_road;
    ycnt_n        = ycnt;
    case (state)
      IDLE: begin
        green_n  = '0;
        yellow_n = '0;
        en_n     = 1'b0;
        if (|jam_roads) begin
          state_n = ARM;
          en_n    = 1'b1;
        end
      end
      ARM: begin
        green_n  = '0;
        yellow_n = '0;
        en_n     = 1'b1;
        // An emptied jam set wins over a simultaneous window start.
        if (jam_roads == '0) begin
          state_n = IDLE;
          en_n    = 1'b0;
        end else if (jam_start) begin
          state_n       = GREEN;
          green_n       = '0;
          green_n[sel]  = 1'b1;
          active_road_n = sel;
          last_road_n   = sel;
        end
      end
      GREEN: begin
        en_n = 1'b1;
        if (jam_rotation || !jam_roads[active_road]) begin
          // Dropping the enable restarts jam_counter for the next window.
          state_n               = YELLOW;
          en_n                  = 1'b0;
          green_n               = '0;
          yellow_n              = '0;
          yellow_n[active_road] = 1'b1;
          ycnt_n                = CW'(YELLOW_CYCLES);
        end
      end
      YELLOW: begin
        en_n = 1'b0;
        if (ycnt <= CW'(1)) begin
          state_n  = ALL_RED;
          yellow_n = '0;
        end else begin
          ycnt_n = ycnt - CW'(1);
        end
      end
      ALL_RED: begin
        green_n  = '0;
        yellow_n = '0;
        if (|jam_roads) begin
          state_n = ARM;
          en_n    = 1'b1;
        end else begin
          state_n = IDLE;
          en_n    = 1'b0;
        end
      end
      default: begin
        state_n  = IDLE;
        green_n  = '0;
        yellow_n = '0;
        en_n     = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any pending selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      green          <= '0;
      yellow         <= '0;
      red            <= '1;
      jam_counter_en <= 1'b0;
      active_road    <= '0;
      jam_mode       <= 1'b0;
      last_road      <= RW'(N_ROADS - 1);
      ycnt           <= '0;
    end else begin
      state          <= state_n;
      green          <= green_n;
      yellow         <= yellow_n;
      red            <= ~(green_n | yellow_n);
      jam_counter_en <= en_n;
      active_road    <= active_road_n;
      jam_mode       <= (state_n != IDLE);
      last_road      <= last_road_n;
      ycnt           <= ycnt_n;
    end
  end

endmodule

// File: tb/tb_jam_light_sequencer.sv
// Testbench for jam_light_sequencer: a reference model predicts every output
// each cycle into a scoreboard queue, plus direct checks of key lamp values.
module tb_jam_light_sequencer;

  localparam int N  = 4;
  localparam int YC = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] jam_roads;
  logic         jam_start;
  logic         jam_rotation;
  logic         jam_counter_en;
  logic [N-1:0] green, yellow, red;
  logic [1:0]   active_road;
  logic         jam_mode;

  jam_light_sequencer #(.N_ROADS(N), .YELLOW_CYCLES(YC)) dut (
    .clk(clk), .rst(rst), .jam_roads(jam_roads), .jam_start(jam_start),
    .jam_rotation(jam_rotation), .jam_counter_en(jam_counter_en),
    .green(green), .yellow(yellow), .red(red), .active_road(active_road),
    .jam_mode(jam_mode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model (phase names: 0 idle, 1 arm, 2 green, 3 yellow, 4 all-red)
  int           m_ph   = 0;
  int           m_last = N - 1;
  int           m_act  = 0;
  int           m_ycnt = 0;
  logic [N-1:0] m_g    = '0;
  logic [N-1:0] m_y    = '0;
  logic         m_en   = 1'b0;

  logic [17:0] exp_q[$];

  function automatic int next_road(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return last;
  endfunction

  task automatic model_next();
    int s;
    if (rst) begin
      m_ph = 0; m_last = N - 1; m_act = 0; m_g = '0; m_y = '0; m_en = 1'b0;
    end else begin
      case (m_ph)
        0: if (jam_roads != 0) begin m_ph = 1; m_en = 1'b1; end
        1: begin
          if (jam_roads == 0) begin
            m_ph = 0; m_en = 1'b0;
          end else if (jam_start) begin
            s = next_road(jam_roads, m_last);
            m_g = N'(1) << s; m_act = s; m_last = s; m_ph = 2;
          end
        end
        2: if (jam_rotation || !jam_roads[m_act]) begin
          m_ph = 3; m_en = 1'b0; m_y = m_g; m_g = '0; m_ycnt = 0;
        end
        3: begin
          m_ycnt++;
          if (m_ycnt == YC) begin m_ph = 4; m_y = '0; end
        end
        default: begin
          if (jam_roads != 0) begin m_ph = 1; m_en = 1'b1; end
          else begin m_ph = 0; m_en = 1'b0; end
        end
      endcase
    end
    exp_q.push_back({m_en, (m_ph != 0), 2'(m_act), m_g, m_y, ~(m_g | m_y)});
  endtask

  // One clock: predict, advance, then compare the whole output vector.
  task automatic step();
    logic [17:0] e;
    model_next();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("cycle", {jam_counter_en, jam_mode, active_road, green, yellow, red}, e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    jam_start = 1'b1; step(); jam_start = 1'b0;
  endtask

  task automatic pulse_rot();
    jam_rotation = 1'b1; step(); jam_rotation = 1'b0;
  endtask

  int  cnt, wins, glen, gr;
  logic en_s;

  task automatic counter_step();
    jam_start    = jam_counter_en && (cnt == 0);
    jam_rotation = jam_counter_en && (cnt == 14);
    en_s = jam_counter_en;
    step();
    cnt = en_s ? cnt + 1 : 0;
  endtask

  initial begin
    rst = 1'b1; jam_roads = '0; jam_start = 1'b0; jam_rotation = 1'b0;
    // reset state
    run(2);
    chk("rst_red", red, 4'b1111);
    chk("rst_green", green, 4'b0000);
    chk("rst_yellow", yellow, 4'b0000);
    chk("rst_en", jam_counter_en, 1'b0);
    chk("rst_mode", jam_mode, 1'b0);
    rst = 1'b0;
    run(2);
    // single jammed road
    jam_roads = 4'b0100;
    step();
    chk("arm_en", jam_counter_en, 1'b1);
    pulse_start();
    chk("g2_green", green, 4'b0100);
    chk("g2_red", red, 4'b1011);
    chk("g2_act", active_road, 2'd2);
    run(2);
    // rotation, yellow timing, round-robin with wrap
    jam_roads = 4'b1101;
    pulse_rot();
    chk("y2_yellow", yellow, 4'b0100);
    chk("y2_en", jam_counter_en, 1'b0);
    run(YC - 1);
    chk("y2_hold", yellow, 4'b0100);
    step();
    chk("allred", red, 4'b1111);
    step();
    chk("rearm_en", jam_counter_en, 1'b1);
    pulse_start();
    chk("g3_green", green, 4'b1000);
    pulse_rot(); run(YC + 1);
    pulse_start();
    chk("wrap_green", green, 4'b0001);
    // jam bit cleared without rotation
    jam_roads = 4'b1111;
    pulse_rot(); run(YC + 1);
    pulse_start();
    chk("g1_green", green, 4'b0010);
    jam_roads = 4'b1101;
    step();
    chk("clr_yellow", yellow, 4'b0010);
    run(YC + 1);
    // lone road re-served, then clear and rotation together
    jam_roads = 4'b0010;
    pulse_start();
    chk("lone_green", green, 4'b0010);
    jam_roads = 4'b1000;
    pulse_rot();
    chk("both_yellow", yellow, 4'b0010);
    run(YC);
    chk("both_allred", red, 4'b1111);
    step();
    // jam cleared during yellow
    pulse_start();
    chk("g3b_green", green, 4'b1000);
    pulse_rot();
    jam_roads = 4'b0000;
    run(YC);
    step();
    chk("idle_en", jam_counter_en, 1'b0);
    chk("idle_mode", jam_mode, 1'b0);
    pulse_start();
    chk("idle_start_ign", green, 4'b0000);
    run(2);
    // integration with a jam_counter model, all roads jammed
    jam_roads = 4'b1111; cnt = 0; wins = 0; glen = 0; gr = 0;
    for (int c = 0; c < 400 && wins < 5; c++) begin
      counter_step();
      if (green != 0) begin
        glen++; gr = int'(active_road);
      end else if (glen != 0) begin
        chk("win_len", glen, 14);
        chk("win_road", gr, wins % N);
        wins++; glen = 0;
      end
    end
    chk("win_count", wins, 5);
    // reset in the middle of a green window
    for (int c = 0; c < 40 && green == 0; c++) counter_step();
    chk("mid_green_up", (green != 0), 1'b1);
    for (int c = 0; c < 5; c++) counter_step();
    rst = 1'b1; jam_start = 1'b0; jam_rotation = 1'b0;
    step();
    chk("mrst_red", red, 4'b1111);
    chk("mrst_en", jam_counter_en, 1'b0);
    chk("mrst_act", active_road, 2'd0);
    rst = 1'b0; cnt = 0;
    for (int c = 0; c < 40 && green == 0; c++) counter_step();
    chk("post_rst_green", green, 4'b0001);
    chk("post_rst_act", active_road, 2'd0);
    jam_start = 1'b0; jam_rotation = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
